// File: rtl/xenoa_sla_breach_tracker.sv
// ----------------------------------------------------------------------------
// xenoa_sla_breach_tracker
//
// Purpose:
//   Consumes boundary-tagged samples from the XENOA boundary-semantics stage.
//   Each sample is checked against a value threshold and a severity
//   threshold. A saturating run counter tracks consecutive exceeding samples.
//   An escalation FSM moves through NORMAL -> WARN -> BREACH -> COOLDOWN.
//   Audit records that arrive while the FSM is escalated are queued in a
//   first-word-fall-through FIFO. The FIFO drains to the escalation/export
//   stage over a valid/ready handshake.
//
// Parameters:
//   DEPTH            FIFO entries (power of 2, >= 2)
//   WARN_COUNT       consecutive exceeding samples needed to enter WARN
//   BREACH_COUNT     consecutive exceeding samples needed to enter BREACH
//   COOLDOWN_CYCLES  cycles spent in COOLDOWN before returning to NORMAL
//
// Ports:
//   clk            clock; all logic is on the rising edge
//   rst_n          synchronous reset, active-low
//   in_key         boundary key of the incoming sample
//   in_value       contract-bound value of the incoming sample
//   in_severity    boundary severity of the incoming sample
//   in_audit       256-bit audit record of the incoming sample
//   in_valid       sample strobe (no backpressure)
//   sla_threshold  value limit; a sample exceeds when in_value > limit
//   sev_threshold  severity limit; a sample exceeds when severity >= limit
//   out_key        key of the FIFO head
//   out_audit      audit record of the FIFO head
//   out_valid      FIFO is non-empty
//   out_ready      consumer accepts the head when out_valid && out_ready
//   sla_state      0 NORMAL, 1 WARN, 2 BREACH, 3 COOLDOWN
//   breach_count   saturating count of BREACH incidents
//   drop_count     saturating count of records lost to a full FIFO
//   fifo_level     current FIFO occupancy
//   out_timestamp  enqueue cycle of the FIFO head (XENOA_SLA_TIMESTAMP_EN only)
//
// Configuration:
//   XENOA_SLA_TIMESTAMP_EN  when defined, a free-running 32-bit cycle
//                           counter is added. Each FIFO entry records the
//                           counter value at its enqueue cycle, and that
//                           value is presented on out_timestamp.
// ----------------------------------------------------------------------------
module xenoa_sla_breach_tracker #(
    parameter int DEPTH           = 8,
    parameter int WARN_COUNT      = 2,
    parameter int BREACH_COUNT    = 4,
    parameter int COOLDOWN_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                in_key,
    input  logic [31:0]                in_value,
    input  logic [7:0]                 in_severity,
    input  logic [255:0]               in_audit,
    input  logic                       in_valid,
    input  logic [31:0]                sla_threshold,
    input  logic [7:0]                 sev_threshold,
    output logic [31:0]                out_key,
    output logic [255:0]               out_audit,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 sla_state,
    output logic [15:0]                breach_count,
    output logic [15:0]                drop_count,
    output logic [$clog2(DEPTH):0]     fifo_level
`ifdef XENOA_SLA_TIMESTAMP_EN
    ,
    output logic [31:0]                out_timestamp
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int RW = $clog2(BREACH_COUNT + 1);
    localparam int TW = $clog2(COOLDOWN_CYCLES + 1);
`ifdef XENOA_SLA_TIMESTAMP_EN
    localparam int EW = 32 + 256 + 32;
`else
    localparam int EW = 32 + 256;
`endif

    localparam logic [RW-1:0] WARN_RUN   = RW'(WARN_COUNT);
    localparam logic [RW-1:0] BREACH_RUN = RW'(BREACH_COUNT);
    localparam logic [TW-1:0] COOL_LOAD  = TW'(COOLDOWN_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_WARN     = 2'd1,
        ST_BREACH   = 2'd2,
        ST_COOLDOWN = 2'd3
    } sla_state_t;

    sla_state_t      state;
    sla_state_t      state_next;
    logic [RW-1:0]   run_cnt;
    logic [RW-1:0]   run_next;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    logic            new_incident;
    logic            exceed;
    logic            clean;

    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   entry_in;
    logic [EW-1:0]   head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;

    // Classify the current sample and compute the run length that the FSM
    // must see this cycle. The run counter saturates at BREACH_COUNT so it
    // never wraps back below the escalation thresholds during a long run.
    always_comb begin
        exceed   = in_valid && ((in_value > sla_threshold) || (in_severity >= sev_threshold));
        clean    = in_valid && !exceed;
        run_next = run_cnt;
        if (exceed) begin
            if (run_cnt != BREACH_RUN) begin
                run_next = run_cnt + RW'(1);
            end
        end else if (clean) begin
            run_next = '0;
        end
    end

    // Next-state decode. It is kept combinational because the enqueue
    // decision depends on where the FSM is heading in this same cycle.
    // A COOLDOWN that sees a new exceed goes back to BREACH as part of the
    // same incident, so only the WARN -> BREACH edge counts a new incident.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        new_incident = 1'b0;
        unique case (state)
            ST_NORMAL: begin
                if (run_next >= WARN_RUN) begin
                    state_next = ST_WARN;
                end
            end
            ST_WARN: begin
                if (run_next >= BREACH_RUN) begin
                    state_next   = ST_BREACH;
                    new_incident = 1'b1;
                end else if (clean) begin
                    state_next = ST_NORMAL;
                end
            end
            ST_BREACH: begin
                if (clean) begin
                    state_next = ST_COOLDOWN;
                    timer_next = COOL_LOAD;
                end
            end
            ST_COOLDOWN: begin
                if (exceed) begin
                    state_next = ST_BREACH;
                end else begin
                    timer_next = timer - TIMER_ONE;
                    if (timer == TIMER_ONE) begin
                        state_next = ST_NORMAL;
                    end
                end
            end
            default: begin
                state_next = ST_NORMAL;
            end
        endcase
    end

    // Escalation state, run counter, cooldown timer and incident counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_NORMAL;
            run_cnt      <= '0;
            timer        <= '0;
            breach_count <= '0;
        end else begin
            state   <= state_next;
            run_cnt <= run_next;
            timer   <= timer_next;
            if (new_incident && (breach_count != 16'hFFFF)) begin
                breach_count <= breach_count + 16'd1;
            end
        end
    end

    assign sla_state = state;

    // Records are queued only while the FSM is escalated or escalating.
    // When the FIFO is full, a push is still accepted if the head leaves
    // in the same cycle. Otherwise the record is dropped and counted.
    assign push_req  = exceed && (state_next != ST_NORMAL);
    assign full      = (fifo_level == FULL_LEVEL);
    assign out_valid = (fifo_level != '0);
    assign pop       = out_valid && out_ready;
    assign push      = push_req && (!full || pop);

`ifdef XENOA_SLA_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running cycle counter that stamps each entry as it is queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end

    assign entry_in      = {in_key, in_audit, ts_cnt};
    assign out_timestamp = head[31:0];
`else
    assign entry_in = {in_key, in_audit};
`endif

    // FIFO storage and pointers. The storage is cleared on reset so the
    // head outputs read zero straight after reset. Pointers are PW bits
    // wide, so they wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry_in;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (push_req && !push && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // First-word-fall-through head: the oldest entry is always on the outputs.
    assign head      = mem[rd_ptr];
    assign out_key   = head[EW-1 -: 32];
    assign out_audit = head[EW-33 -: 256];

endmodule

// File: tb/tb_xenoa_sla_breach_tracker.sv
// ----------------------------------------------------------------------------
// tb_xenoa_sla_breach_tracker
//
// Directed testbench for xenoa_sla_breach_tracker with default parameters
// (DEPTH 8, WARN 2, BREACH 4, COOLDOWN 16). Inputs change 1 time unit after
// each rising edge, and outputs are sampled at that same point, so every
// check sees the state left by the previous edge.
// ----------------------------------------------------------------------------
module tb_xenoa_sla_breach_tracker;

    logic         clk;
    logic         rst_n;
    logic [31:0]  in_key;
    logic [31:0]  in_value;
    logic [7:0]   in_severity;
    logic [255:0] in_audit;
    logic         in_valid;
    logic [31:0]  sla_threshold;
    logic [7:0]   sev_threshold;
    logic [31:0]  out_key;
    logic [255:0] out_audit;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   sla_state;
    logic [15:0]  breach_count;
    logic [15:0]  drop_count;
    logic [3:0]   fifo_level;

    int tests;
    int failures;

    xenoa_sla_breach_tracker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_key        (in_key),
        .in_value      (in_value),
        .in_severity   (in_severity),
        .in_audit      (in_audit),
        .in_valid      (in_valid),
        .sla_threshold (sla_threshold),
        .sev_threshold (sev_threshold),
        .out_key       (out_key),
        .out_audit     (out_audit),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sla_state     (sla_state),
        .breach_count  (breach_count),
        .drop_count    (drop_count),
        .fifo_level    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] key, input logic [31:0] value, input logic [7:0] sev);
        in_valid    = 1'b1;
        in_key      = key;
        in_value    = value;
        in_severity = sev;
        in_audit    = {8{key}};
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Reset state after power-up, then a reset while the FIFO holds three entries.
    task automatic test_reset();
        do_reset();
        tests++; if (sla_state !== 2'd0) begin failures++; $display("[TB] FAIL t1_init_state got %0d want 0", sla_state); end
        tests++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t1_init_valid got %0d want 0", out_valid); end
        tests++; if (fifo_level !== 4'd0) begin failures++; $display("[TB] FAIL t1_init_level got %0d want 0", fifo_level); end
        for (int i = 0; i < 4; i++) begin
            drive(32'(100 + i), 32'd200, 8'd0);
            tick();
        end
        idle();
        tests++; if (fifo_level !== 4'd3) begin failures++; $display("[TB] FAIL t1_fill_level got %0d want 3", fifo_level); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t1_rst_valid got %0d want 0", out_valid); end
        tests++; if (fifo_level !== 4'd0) begin failures++; $display("[TB] FAIL t1_rst_level got %0d want 0", fifo_level); end
        tests++; if (sla_state !== 2'd0) begin failures++; $display("[TB] FAIL t1_rst_state got %0d want 0", sla_state); end
        tests++; if (breach_count !== 16'd0) begin failures++; $display("[TB] FAIL t1_rst_breach got %0d want 0", breach_count); end
        tests++; if (drop_count !== 16'd0) begin failures++; $display("[TB] FAIL t1_rst_drop got %0d want 0", drop_count); end
        tests++; if (out_key !== 32'd0) begin failures++; $display("[TB] FAIL t1_rst_key got %0d want 0", out_key); end
    endtask

    // Four back-to-back value exceeds walk the FSM to BREACH; samples 2..4 are queued.
    task automatic test_escalation();
        logic [1:0] exp_state [4];
        exp_state[0] = 2'd0; exp_state[1] = 2'd1; exp_state[2] = 2'd1; exp_state[3] = 2'd2;
        do_reset();
        sla_threshold = 32'd100;
        sev_threshold = 8'd8;
        for (int i = 0; i < 4; i++) begin
            drive(32'(10 + i), 32'd200, 8'd0);
            tick();
            tests++; if (sla_state !== exp_state[i]) begin failures++; $display("[TB] FAIL t2_state%0d got %0d want %0d", i, sla_state, exp_state[i]); end
        end
        idle();
        tests++; if (breach_count !== 16'd1) begin failures++; $display("[TB] FAIL t2_breach got %0d want 1", breach_count); end
        tests++; if (fifo_level !== 4'd3) begin failures++; $display("[TB] FAIL t2_level got %0d want 3", fifo_level); end
        tests++; if (out_audit !== {8{32'd11}}) begin failures++; $display("[TB] FAIL t2_audit got %h want %h", out_audit, {8{32'd11}}); end
        out_ready = 1'b1;
        for (int k = 11; k <= 13; k++) begin
            tests++; if (out_key !== 32'(k)) begin failures++; $display("[TB] FAIL t2_key got %0d want %0d", out_key, k); end
            tick();
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t2_empty got %0d want 0", out_valid); end
        tests++; if (sla_state !== 2'd2) begin failures++; $display("[TB] FAIL t2_hold got %0d want 2", sla_state); end
    endtask

    // Runs directly after test_escalation, with the FSM in BREACH.
    task automatic test_cooldown();
        int cool_cycles;
        drive(32'd50, 32'd50, 8'd0);
        tick();
        idle();
        cool_cycles = 0;
        if (sla_state == 2'd3) cool_cycles++;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (sla_state == 2'd3) cool_cycles++;
        end
        tests++; if (cool_cycles != 16) begin failures++; $display("[TB] FAIL t3_cool_len got %0d want 16", cool_cycles); end
        tick();
        tests++; if (sla_state !== 2'd0) begin failures++; $display("[TB] FAIL t3_normal got %0d want 0", sla_state); end
        tests++; if (fifo_level !== 4'd0) begin failures++; $display("[TB] FAIL t3_noenq got %0d want 0", fifo_level); end
        for (int i = 0; i < 4; i++) begin
            drive(32'(20 + i), 32'd200, 8'd0);
            tick();
        end
        tests++; if (breach_count !== 16'd2) begin failures++; $display("[TB] FAIL t3_breach2 got %0d want 2", breach_count); end
        drive(32'd30, 32'd10, 8'd0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        tests++; if (sla_state !== 2'd3) begin failures++; $display("[TB] FAIL t3_cool4 got %0d want 3", sla_state); end
        drive(32'd31, 32'd500, 8'd0);
        tick();
        idle();
        tests++; if (sla_state !== 2'd2) begin failures++; $display("[TB] FAIL t3_rebreach got %0d want 2", sla_state); end
        tests++; if (breach_count !== 16'd2) begin failures++; $display("[TB] FAIL t3_same_incident got %0d want 2", breach_count); end
        tests++; if (fifo_level !== 4'd4) begin failures++; $display("[TB] FAIL t3_level got %0d want 4", fifo_level); end
    endtask

    // Severity path at its boundary, plus the strict value comparison boundary.
    task automatic test_severity();
        do_reset();
        sla_threshold = 32'd100;
        sev_threshold = 8'd8;
        drive(32'd40, 32'd0, 8'd8); tick();
        drive(32'd41, 32'd0, 8'd8); tick();
        tests++; if (sla_state !== 2'd1) begin failures++; $display("[TB] FAIL t4_sev_warn got %0d want 1", sla_state); end
        tests++; if (fifo_level !== 4'd1) begin failures++; $display("[TB] FAIL t4_sev_enq got %0d want 1", fifo_level); end
        drive(32'd42, 32'd0, 8'd7); tick();
        tests++; if (sla_state !== 2'd0) begin failures++; $display("[TB] FAIL t4_sev7_clean got %0d want 0", sla_state); end
        drive(32'd43, 32'd0, 8'd8); tick();
        tests++; if (sla_state !== 2'd0) begin failures++; $display("[TB] FAIL t4_run_cleared got %0d want 0", sla_state); end
        drive(32'd44, 32'd100, 8'd0); tick();
        drive(32'd45, 32'd101, 8'd0); tick();
        tests++; if (sla_state !== 2'd0) begin failures++; $display("[TB] FAIL t4_val_eq got %0d want 0", sla_state); end
        drive(32'd46, 32'd101, 8'd0); tick();
        idle();
        tests++; if (sla_state !== 2'd1) begin failures++; $display("[TB] FAIL t4_val_gt got %0d want 1", sla_state); end
        tests++; if (fifo_level !== 4'd2) begin failures++; $display("[TB] FAIL t4_level got %0d want 2", fifo_level); end
        tests++; if (out_key !== 32'd41) begin failures++; $display("[TB] FAIL t4_head got %0d want 41", out_key); end
    endtask

    // Ten enqueue attempts into an 8-deep FIFO, then push and pop in the same cycle, then drain.
    task automatic test_full_fifo();
        logic [31:0] exp_keys [8];
        do_reset();
        for (int i = 1; i <= 11; i++) begin
            drive(32'(i), 32'd999, 8'd0);
            tick();
        end
        idle();
        tests++; if (fifo_level !== 4'd8) begin failures++; $display("[TB] FAIL t5_level got %0d want 8", fifo_level); end
        tests++; if (drop_count !== 16'd2) begin failures++; $display("[TB] FAIL t5_drop got %0d want 2", drop_count); end
        tests++; if (out_key !== 32'd2) begin failures++; $display("[TB] FAIL t5_head got %0d want 2", out_key); end
        drive(32'd12, 32'd999, 8'd0);
        out_ready = 1'b1;
        tick();
        idle();
        tests++; if (fifo_level !== 4'd8) begin failures++; $display("[TB] FAIL t5_pp_level got %0d want 8", fifo_level); end
        tests++; if (drop_count !== 16'd2) begin failures++; $display("[TB] FAIL t5_pp_drop got %0d want 2", drop_count); end
        for (int i = 0; i < 7; i++) exp_keys[i] = 32'(3 + i);
        exp_keys[7] = 32'd12;
        for (int i = 0; i < 8; i++) begin
            tests++; if (out_key !== exp_keys[i]) begin failures++; $display("[TB] FAIL t5_drain%0d got %0d want %0d", i, out_key, exp_keys[i]); end
            tick();
        end
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t5_empty got %0d want 0", out_valid); end
    endtask

    // Keys 1..8 drained under an irregular out_ready pattern must come out once each, in order.
    task automatic test_drain_order();
        logic [15:0] pat;
        logic [31:0] exp_key;
        int got;
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            drive(32'(i), 32'd999, 8'd0);
            tick();
        end
        idle();
        tests++; if (fifo_level !== 4'd8) begin failures++; $display("[TB] FAIL t6_level got %0d want 8", fifo_level); end
        pat     = 16'b1011_0010_1110_0101;
        exp_key = 32'd1;
        got     = 0;
        for (int c = 0; c < 64 && got < 8; c++) begin
            out_ready = pat[c % 16];
            if (out_valid && out_ready) begin
                tests++; if (out_key !== exp_key) begin failures++; $display("[TB] FAIL t6_key got %0d want %0d", out_key, exp_key); end
                exp_key = exp_key + 32'd1;
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        tests++; if (got != 8) begin failures++; $display("[TB] FAIL t6_count got %0d want 8", got); end
        tests++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL t6_empty got %0d want 0", out_valid); end
    endtask

    initial begin
        tests         = 0;
        failures      = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_key        = '0;
        in_value      = '0;
        in_severity   = '0;
        in_audit      = '0;
        out_ready     = 1'b0;
        sla_threshold = 32'd100;
        sev_threshold = 8'd8;
        test_reset();
        test_escalation();
        test_cooldown();
        test_severity();
        test_full_fifo();
        test_drain_order();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
